// File: rtl/cpu_core.sv
// cpu_core: single-cycle RV32I integer core (one instruction committed per
// rising clock edge) with internal word-addressed instruction and data memories.
//
// Ports
//   clk          system clock; every state update happens on its rising edge
//   rst          synchronous, active-high reset (PC <= RESET_PC, x1..x31 <= 0)
//   pc_out       address of the instruction executing this cycle
//   instr_out    instruction word fetched from pc_out this cycle
//   dbg_reg_addr register-file debug read index
//   dbg_reg_data combinational x[dbg_reg_addr]; x0 always reads 0
//
// Sub-instances other code reaches into:
//   instr_memory_item.mem : instruction storage, preloaded hierarchically
//   data_memory_item.mem  : data storage
//   pc_item.next_pc       : the PC register itself

// Word-wide memory with one synchronous write port and one asynchronous read
// port. Used for both instruction and data storage.
//   clk, we, waddr, wdata : write port (written on the rising edge when we=1)
//   raddr, rdata          : combinational read port
module cpu_mem #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);
    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// Program counter register.
//   clk, rst : clock and synchronous reset (loads RESET_PC)
//   target   : address of the next instruction, computed by the core
//   pc       : current PC
// next_pc is the PC register. Writing it hierarchically before the first edge
// selects the first executed address without going through reset.
module cpu_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] target,
    output logic [31:0] pc
);
    logic [31:0] next_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            next_pc <= RESET_PC;
        end else begin
            next_pc <= target;
        end
    end

    assign pc = next_pc;
endmodule

module cpu_core #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    input  logic [4:0]  dbg_reg_addr,
    output logic [31:0] dbg_reg_data
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0]    pc;
    logic [31:0]    pc_plus4;
    logic [31:0]    target;
    logic [31:0]    instr;
    logic [IAW-1:0] iaddr;
    logic [DAW-1:0] daddr;
    logic [31:0]    mem_off;
    logic [31:0]    dmem_rdata;

    logic [6:0]     opcode;
    logic [4:0]     rd;
    logic [2:0]     funct3;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [6:0]     funct7;
    logic [31:0]    imm_i;
    logic [31:0]    imm_s;
    logic [31:0]    imm_b;
    logic [31:0]    imm_u;
    logic [31:0]    imm_j;
    logic [31:0]    rs1v;
    logic [31:0]    rs2v;

    logic           imm_legal;
    logic           reg_legal;
    logic           take;
    logic           wb_en;
    logic [31:0]    wb_data;
    logic           store_en;

    logic [31:0]    regs [0:31];

    // ---------------------------------------------------------------- fetch
    cpu_pc #(.RESET_PC(RESET_PC)) pc_item (
        .clk    (clk),
        .rst    (rst),
        .target (target),
        .pc     (pc)
    );

    // pc[1:0] is dropped; addresses past the end wrap around the array.
    assign iaddr = IAW'((pc >> 2) % IMEM_DEPTH);

    // The write port is unused by the core; programs arrive by hierarchical
    // preload of instr_memory_item.mem.
    cpu_mem #(.DEPTH(IMEM_DEPTH)) instr_memory_item (
        .clk   (clk),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .raddr (iaddr),
        .rdata (instr)
    );

    assign pc_plus4  = pc + 32'd4;
    assign pc_out    = pc;
    assign instr_out = instr;

    // --------------------------------------------------------------- decode
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Shift immediates carry funct7 in imm[11:5]; only SRAI may set bit 30.
    assign imm_legal = (funct3 == 3'b001) ? (funct7 == 7'b0000000) :
                       (funct3 == 3'b101) ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) :
                       1'b1;
    assign reg_legal = (funct7 == 7'b0000000) ||
                       (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));

    // -------------------------------------------------------- register file
    // Reads see the pre-edge value even when the same register is written.
    assign rs1v         = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2v         = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
    assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : regs[dbg_reg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_en && rd != 5'd0) begin
            regs[rd] <= wb_data;
        end
    end

    // ---------------------------------------------------------- data memory
    assign mem_off = (opcode == OP_STORE) ? imm_s : imm_i;
    assign daddr   = DAW'(((rs1v + mem_off) >> 2) % DMEM_DEPTH);

    // A reset edge aborts the instruction in flight, including its store.
    cpu_mem #(.DEPTH(DMEM_DEPTH)) data_memory_item (
        .clk   (clk),
        .we    (store_en && !rst),
        .waddr (daddr),
        .wdata (rs2v),
        .raddr (daddr),
        .rdata (dmem_rdata)
    );

    // ------------------------------------------------------------------ alu
    // alt selects SUB for funct3=000 and arithmetic right shift for 101.
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        r;
        logic signed [31:0] sra;
        sra = $signed(a) >>> b[4:0];
        r   = 32'd0;
        case (f3)
            3'b000:  r = alt ? (a - b) : (a + b);
            3'b001:  r = a << b[4:0];
            3'b010:  r = {31'd0, $signed(a) < $signed(b)};
            3'b011:  r = {31'd0, a < b};
            3'b100:  r = a ^ b;
            3'b101:  r = alt ? sra : (a >> b[4:0]);
            3'b110:  r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------- execute
    // Anything not decoded below (including illegal funct fields) falls
    // through the defaults and behaves as a NOP.
    always_comb begin
        target   = pc_plus4;
        wb_en    = 1'b0;
        wb_data  = 32'd0;
        store_en = 1'b0;
        take     = 1'b0;
        case (opcode)
            OP_LUI: begin
                wb_en   = 1'b1;
                wb_data = imm_u;
            end
            OP_AUIPC: begin
                wb_en   = 1'b1;
                wb_data = pc + imm_u;
            end
            OP_JAL: begin
                wb_en   = 1'b1;
                wb_data = pc_plus4;
                target  = pc + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    wb_en   = 1'b1;
                    wb_data = pc_plus4;
                    target  = (rs1v + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  take = (rs1v == rs2v);
                    3'b001:  take = (rs1v != rs2v);
                    3'b100:  take = ($signed(rs1v) <  $signed(rs2v));
                    3'b101:  take = ($signed(rs1v) >= $signed(rs2v));
                    3'b110:  take = (rs1v <  rs2v);
                    3'b111:  take = (rs1v >= rs2v);
                    default: take = 1'b0;
                endcase
                if (take) begin
                    target = pc + imm_b;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    wb_en   = 1'b1;
                    wb_data = dmem_rdata;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    store_en = 1'b1;
                end
            end
            OP_IMM: begin
                if (imm_legal) begin
                    wb_en   = 1'b1;
                    wb_data = alu(funct3, (funct3 == 3'b101) && instr[30], rs1v, imm_i);
                end
            end
            OP_REG: begin
                if (reg_legal) begin
                    wb_en   = 1'b1;
                    wb_data = alu(funct3, instr[30], rs1v, rs2v);
                end
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed and randomized program runs for cpu_core, compared
// against an instruction-level RV32I interpreter kept in this file.
module tb_cpu_core;
    localparam int          IMEM_DEPTH = 256;
    localparam int          DMEM_DEPTH = 256;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [4:0]  dbg_reg_addr = 5'd0;
    logic [31:0] dbg_reg_data;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference architectural state.
    logic [31:0] m_imem [IMEM_DEPTH];
    logic [31:0] m_dmem [DMEM_DEPTH];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [31:0] exp_q [$];
    logic [31:0] prog [$];

    cpu_core #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .DMEM_DEPTH (DMEM_DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_out       (pc_out),
        .instr_out    (instr_out),
        .dbg_reg_addr (dbg_reg_addr),
        .dbg_reg_data (dbg_reg_data)
    );

    // ------------------------------------------------------ clock / reset
    always #50 clk = ~clk;

    // ----------------------------------------------------------- encoders
    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3, int op);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'(op)};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
    endfunction

    function automatic int rimm12();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    // Mostly well-formed instructions over x0..x7, plus illegal encodings.
    function automatic logic [31:0] rand_instr();
        int k, rd, rs1, rs2, f3, f7, sel;
        k   = $urandom_range(0, 15);
        rd  = $urandom_range(0, 7);
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        f3  = $urandom_range(0, 7);
        sel = $urandom_range(0, 7);
        f7  = (sel < 4) ? 0 : (sel < 7) ? 32 : int'($urandom_range(0, 127));
        case (k)
            0:  return enc_u(int'($urandom), rd, 7'h37);
            1:  return enc_u(int'($urandom), rd, 7'h17);
            2:  return enc_j((int'($urandom_range(0, 16)) - 8) * 4, rd);
            3:  return enc_i(rimm12(), rs1, ($urandom_range(0, 3) == 0) ? 1 : 0, rd, 7'h67);
            4:  return enc_b((int'($urandom_range(0, 16)) - 8) * 4, rs2, rs1, f3);
            5:  return enc_i(rimm12(), rs1, ($urandom_range(0, 3) == 0) ? f3 : 2, rd, 7'h03);
            6:  return enc_s(rimm12(), rs2, rs1, ($urandom_range(0, 3) == 0) ? f3 : 2, 7'h23);
            7, 8: begin
                if (f3 == 1 || f3 == 5)
                    return enc_i(f7 * 32 + int'($urandom_range(0, 31)), rs1, f3, rd, 7'h13);
                return enc_i(rimm12(), rs1, f3, rd, 7'h13);
            end
            9, 10: return enc_r(f7, rs2, rs1, f3, rd);
            11: return 32'h0000_0000;
            12: return $urandom;
            default: return enc_i(rimm12(), ($urandom_range(0, 1) == 0) ? 0 : rs1, 0, rd, 7'h13);
        endcase
    endfunction

    // ------------------------------------------------------ reference model
    function automatic int widx(logic [31:0] addr, int depth);
        return int'((addr >> 2) % depth);
    endfunction

    function automatic logic [31:0] sx(logic [31:0] v, int bits);
        return 32'($signed(v << (32 - bits)) >>> (32 - bits));
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC;
        for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, y, wb, nxt, imm_i;
        logic signed [31:0] sra;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] rd;
        logic wen, take, ok, sub, arith;
        ins   = m_imem[widx(m_pc, IMEM_DEPTH)];
        op    = ins[6:0];
        rd    = ins[11:7];
        f3    = ins[14:12];
        f7    = ins[31:25];
        a     = m_regs[ins[19:15]];
        b     = m_regs[ins[24:20]];
        imm_i = sx({20'd0, ins[31:20]}, 12);
        nxt   = m_pc + 32'd4;
        wen   = 1'b0;
        wb    = 32'd0;
        take  = 1'b0;
        case (op)
            7'h37: begin wen = 1'b1; wb = ins & 32'hFFFF_F000; end
            7'h17: begin wen = 1'b1; wb = m_pc + (ins & 32'hFFFF_F000); end
            7'h6f: begin
                wen = 1'b1;
                wb  = m_pc + 32'd4;
                nxt = m_pc + sx({11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
            end
            7'h67: if (f3 == 3'd0) begin
                wen = 1'b1;
                wb  = m_pc + 32'd4;
                nxt = (a + imm_i) & 32'hFFFF_FFFE;
            end
            7'h63: begin
                case (f3)
                    3'd0:    take = (a == b);
                    3'd1:    take = (a != b);
                    3'd4:    take = ($signed(a) <  $signed(b));
                    3'd5:    take = ($signed(a) >= $signed(b));
                    3'd6:    take = (a <  b);
                    3'd7:    take = (a >= b);
                    default: take = 1'b0;
                endcase
                if (take)
                    nxt = m_pc + sx({19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
            end
            7'h03: if (f3 == 3'd2) begin
                wen = 1'b1;
                wb  = m_dmem[widx(a + imm_i, DMEM_DEPTH)];
            end
            7'h23: if (f3 == 3'd2)
                m_dmem[widx(a + sx({20'd0, ins[31:25], ins[11:7]}, 12), DMEM_DEPTH)] = b;
            7'h13, 7'h33: begin
                y = (op == 7'h13) ? imm_i : b;
                if (op == 7'h13)
                    ok = (f3 == 3'd1) ? (f7 == 7'd0) :
                         (f3 == 3'd5) ? (f7 == 7'd0 || f7 == 7'd32) : 1'b1;
                else
                    ok = (f7 == 7'd0) || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5));
                sub   = (op == 7'h33) && (f7 == 7'd32) && (f3 == 3'd0);
                arith = (f3 == 3'd5) && (f7 == 7'd32);
                sra   = $signed(a) >>> y[4:0];
                case (f3)
                    3'd0:    wb = sub ? a - y : a + y;
                    3'd1:    wb = a << y[4:0];
                    3'd2:    wb = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                    3'd3:    wb = (a < y) ? 32'd1 : 32'd0;
                    3'd4:    wb = a ^ y;
                    3'd5:    wb = arith ? sra : a >> y[4:0];
                    3'd6:    wb = a | y;
                    default: wb = a & y;
                endcase
                wen = ok;
            end
            default: begin end
        endcase
        if (wen && rd != 5'd0) m_regs[rd] = wb;
        m_pc = nxt;
    endtask

    // ------------------------------------------------------ driver tasks
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_prog(input logic [31:0] p [$]);
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            m_imem[i] = (i < p.size()) ? p[i] : 32'd0;
            dut.instr_memory_item.mem[i] = m_imem[i];
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("reset_pc", pc_out, RESET_PC);
    endtask

    // One committed instruction per cycle; the expected PC is queued before
    // the edge and retired after it.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            model_step();
            exp_q.push_back(m_pc);
            @(posedge clk);
            #1;
            check("pc", pc_out, exp_q.pop_front());
            check("instr", instr_out, m_imem[widx(m_pc, IMEM_DEPTH)]);
        end
    endtask

    task automatic check_reg(input int r, input logic [31:0] exp);
        dbg_reg_addr = 5'(r);
        #1;
        check($sformatf("x%0d", r), dbg_reg_data, exp);
    endtask

    task automatic check_all_regs();
        for (int r = 0; r < 32; r++) check_reg(r, m_regs[r]);
    endtask

    task automatic check_dmem();
        for (int i = 0; i < DMEM_DEPTH; i++)
            check($sformatf("dmem[%0d]", i), dut.data_memory_item.mem[i], m_dmem[i]);
    endtask

    // ------------------------------------------------------ stimulus
    initial begin
        for (int i = 0; i < DMEM_DEPTH; i++) begin
            m_dmem[i] = 32'd0;
            dut.data_memory_item.mem[i] = 32'd0;
        end

        // Basic ADDI, then zero words as NOPs.
        prog = {};
        prog.push_back(enc_i(5, 0, 0, 1, 7'h13));
        prog.push_back(enc_i(6, 0, 0, 2, 7'h13));
        prog.push_back(enc_i(0, 0, 0, 3, 7'h13));
        load_prog(prog);
        apply_reset();
        check_all_regs();
        run(3);
        check("t1_pc", pc_out, 32'd12);
        check_reg(1, 32'd5);
        check_reg(2, 32'd6);
        check_reg(3, 32'd0);
        run(3);
        check("t1_nop_pc", pc_out, 32'd24);
        check_reg(1, 32'd5);

        // Signed/unsigned compares and shifts of all-ones.
        prog = {};
        prog.push_back(enc_i(-1, 0, 0, 1, 7'h13));
        prog.push_back(enc_i(1, 1, 3, 2, 7'h13));
        prog.push_back(enc_i(0, 1, 2, 3, 7'h13));
        prog.push_back(enc_i(32'h400 + 4, 1, 5, 4, 7'h13));
        prog.push_back(enc_i(28, 1, 5, 5, 7'h13));
        load_prog(prog);
        apply_reset();
        run(5);
        check_reg(1, 32'hFFFF_FFFF);
        check_reg(2, 32'h0000_0000);
        check_reg(3, 32'h0000_0001);
        check_reg(4, 32'hFFFF_FFFF);
        check_reg(5, 32'h0000_000F);

        // Store/load round trip and write to x0.
        prog = {};
        prog.push_back(enc_i(7, 0, 0, 1, 7'h13));
        prog.push_back(enc_s(8, 1, 0, 2, 7'h23));
        prog.push_back(enc_i(8, 0, 2, 2, 7'h03));
        prog.push_back(enc_i(9, 0, 0, 0, 7'h13));
        load_prog(prog);
        apply_reset();
        run(4);
        check_reg(2, 32'd7);
        check_reg(0, 32'd0);
        check("t3_dmem2", dut.data_memory_item.mem[2], 32'd7);

        // Countdown loop then JAL.
        prog = {};
        prog.push_back(enc_i(3, 0, 0, 1, 7'h13));
        prog.push_back(enc_i(-1, 1, 0, 1, 7'h13));
        prog.push_back(enc_b(-4, 0, 1, 1));
        prog.push_back(enc_j(8, 5));
        load_prog(prog);
        apply_reset();
        run(7);
        check("t4_loop_pc", pc_out, 32'd12);
        check_reg(1, 32'd0);
        run(1);
        check("t4_jal_pc", pc_out, 32'd20);
        check_reg(5, 32'd16);

        // LUI / AUIPC, with AUIPC at 0x20.
        prog = {};
        for (int i = 0; i < 7; i++) prog.push_back(32'd0);
        prog.push_back(enc_u(32'h12345, 6, 7'h37));
        prog.push_back(enc_u(1, 7, 7'h17));
        load_prog(prog);
        apply_reset();
        run(9);
        check("t5_pc", pc_out, 32'h24);
        check_reg(6, 32'h1234_5000);
        check_reg(7, 32'h0000_1020);

        // Random programs against the interpreter.
        for (int p = 0; p < 4; p++) begin
            prog = {};
            for (int i = 0; i < 64; i++) prog.push_back(rand_instr());
            load_prog(prog);
            apply_reset();
            for (int c = 0; c < 5; c++) begin
                run(30);
                check_all_regs();
            end
            check_dmem();
        end

        // Reset in the middle of a random program.
        prog = {};
        for (int i = 0; i < 64; i++) prog.push_back(rand_instr());
        load_prog(prog);
        apply_reset();
        run(40);
        apply_reset();
        check("mid_rst_instr", instr_out, prog[0]);
        for (int r = 0; r < 32; r++) check_reg(r, 32'd0);
        check_dmem();
        run(40);
        check_all_regs();
        check_dmem();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Single-cycle (one instruction per clock) RV32I integer core with internal word-addressed instruction and data memories.
- Top of the processor hierarchy. Test programs are preloaded by hierarchical write into the instruction memory array; the PC is forced via the PC register instance.
- Architectural state is exposed through debug ports for verification.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit words in instruction memory.
- DMEM_DEPTH, 256, number of 32-bit words in data memory.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_out  output  32  current PC (address of instruction executing this cycle).
- instr_out  output  32  instruction currently fetched.
- dbg_reg_addr  input  5  register-file debug read index.
- dbg_reg_data  output  32  combinational value of x[dbg_reg_addr]; x0 reads 0.

Behaviour:
- Required sub-instance names, relied on by benches:
  - instr_memory_item: array reg [31:0] mem[0:IMEM_DEPTH-1].
  - pc_item: holds reg [31:0] next_pc.
  - The PC register loads next_pc each rising edge.
  - Setting pc_item.next_pc at time 0 defines the first PC.
- Fetch: instr = mem[pc[31:2]] (combinational). Addresses beyond depth wrap modulo IMEM_DEPTH. pc[1:0] is ignored.
- Reset: on a rising edge with rst=1:
  - PC <= RESET_PC.
  - All x1..x31 <= 0.
  - No memory writes.
  - Data and instruction memory contents are retained.
  - Reset mid-program aborts the current instruction: no register-file write that cycle.
- Execution: each non-reset edge commits exactly one instruction. Register writeback and store happen on that edge. Latency is 1 cycle.
- Supported instructions:
  - LUI, AUIPC.
  - JAL, JALR: rd = pc+4; JALR target = (rs1+imm) & ~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: target pc+imm, else pc+4.
  - LW, SW: word only, address bits [1:0] ignored, data memory wraps modulo DMEM_DEPTH.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Immediates are sign-extended per the RV32I I/S/B/U/J formats. Shift amount is 5 bits (imm[4:0] or rs2[4:0]).
- Arithmetic is 32-bit modulo 2^32. Overflow is ignored; no traps.
- x0 is hardwired to 0; writes to rd=0 are discarded.
- Register file: two asynchronous read ports plus the debug port; one synchronous write port. A read of the register being written this cycle returns the old value.
- Unsupported or illegal opcodes (including all-zero words) execute as NOP: pc+4, no writes.
- Data memory: synchronous write on SW, asynchronous read for LW. Initial contents are 0.
- pc+4 wraps at 2^32.

Test Plan:
- Preload mem[0]=addi x1,x0,5; mem[1]=addi x2,x0,6; mem[2]=addi x3,x0,0; next_pc=0 -> after 3 edges x1=5, x2=6, x3=0, pc_out=12; following all-zero words act as NOPs, pc advances by 4 per cycle.
- addi x1,x0,-1; sltiu x2,x1,1; slti x3,x1,0; srai x4,x1,4; srli x5,x1,28 -> x1=0xFFFFFFFF, x2=0, x3=1, x4=0xFFFFFFFF, x5=0xF.
- addi x1,x0,7; sw x1,8(x0); lw x2,8(x0) -> x2=7; addi x0,x0,9 -> x0 remains 0.
- Branch loop: x1=3, loop: addi x1,x1,-1; bne x1,x0,-4 -> exits with x1=0 after 7 instructions; jal x5,8 -> x5=pc+4, pc jumps +8.
- lui x6,0x12345; auipc x7,1 at pc=0x20 -> x6=0x12345000, x7=0x1020.
- Assert rst for one edge mid-program -> pc_out=0, all registers 0, memory preserved, execution restarts from mem[0].
